// File: rtl/carpma_birimi_pkg.sv
// Shared definitions for the iterative shift-add multiplier: RV32M operation
// codes, FSM state encoding and the operand magnitude helper.
package carpma_birimi_pkg;

    localparam logic [1:0] CARPMA_MUL    = 2'b00;
    localparam logic [1:0] CARPMA_MULH   = 2'b01;
    localparam logic [1:0] CARPMA_MULHSU = 2'b10;
    localparam logic [1:0] CARPMA_MULHU  = 2'b11;

    localparam logic [4:0] SON_ADIM = 5'd31;

    typedef enum logic [1:0] {
        BOS     = 2'b00,
        HESAPLA = 2'b01,
        SONUC   = 2'b10
    } durum_t;

    // 0x80000000 maps to itself, which is its correct unsigned magnitude.
    function automatic logic [31:0] mutlak(input logic [31:0] deger, input logic isaretli);
        logic [31:0] sonuc_v;
        if (isaretli && deger[31]) begin
            sonuc_v = ~deger + 32'd1;
        end else begin
            sonuc_v = deger;
        end
        return sonuc_v;
    endfunction

endpackage

// File: rtl/carpma_birimi.sv
// Iterative radix-2 shift-add multiplier for MUL/MULH/MULHSU/MULHU.
// Magnitudes are multiplied unsigned; the sign is applied in the result cycle.
module carpma_birimi
    import carpma_birimi_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        basla_i,
    input  logic [1:0]  islem_i,
    input  logic [31:0] carpilan_i,
    input  logic [31:0] carpan_i,
    output logic [31:0] sonuc_o,
    output logic        bitti_o
);

    durum_t      durum_r, durum_s;
    logic [4:0]  sayac_r, sayac_s;
    logic [63:0] carpim_r, carpim_s;
    logic [31:0] carpilan_r, carpilan_s;
    logic        isaret_r, isaret_s;
    logic [1:0]  islem_r, islem_s;
    logic        carpilan_isaretli_s;
    logic        carpan_isaretli_s;
    logic [32:0] toplam_s;
    logic [63:0] carpim_son_s;

    // Operand signedness implied by the incoming operation code
    always_comb begin
        carpilan_isaretli_s = (islem_i == CARPMA_MULH) || (islem_i == CARPMA_MULHSU);
        carpan_isaretli_s   = (islem_i == CARPMA_MULH);
    end

    // Next-state and datapath update; a dropped request returns to BOS
    always_comb begin
        durum_s    = durum_r;
        sayac_s    = sayac_r;
        carpim_s   = carpim_r;
        carpilan_s = carpilan_r;
        isaret_s   = isaret_r;
        islem_s    = islem_r;
        toplam_s   = {1'b0, carpim_r[63:32]} + (carpim_r[0] ? {1'b0, carpilan_r} : 33'd0);
        case (durum_r)
            BOS: begin
                if (basla_i) begin
                    islem_s    = islem_i;
                    carpilan_s = mutlak(carpilan_i, carpilan_isaretli_s);
                    carpim_s   = {32'd0, mutlak(carpan_i, carpan_isaretli_s)};
                    isaret_s   = (carpilan_isaretli_s & carpilan_i[31]) ^
                                 (carpan_isaretli_s & carpan_i[31]);
                    sayac_s    = 5'd0;
                    durum_s    = HESAPLA;
                end else begin
                    durum_s = BOS;
                end
            end
            HESAPLA: begin
                if (!basla_i) begin
                    durum_s = BOS;
                    sayac_s = 5'd0;
                end else begin
                    carpim_s = {toplam_s, carpim_r[31:1]};
                    sayac_s  = sayac_r + 5'd1;
                    if (sayac_r == SON_ADIM) begin
                        durum_s = SONUC;
                    end else begin
                        durum_s = HESAPLA;
                    end
                end
            end
            SONUC: begin
                durum_s = BOS;
                sayac_s = 5'd0;
            end
            default: begin
                durum_s = BOS;
                sayac_s = 5'd0;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            durum_r    <= BOS;
            sayac_r    <= 5'd0;
            carpim_r   <= 64'd0;
            carpilan_r <= 32'd0;
            isaret_r   <= 1'b0;
            islem_r    <= 2'b00;
        end else begin
            durum_r    <= durum_s;
            sayac_r    <= sayac_s;
            carpim_r   <= carpim_s;
            carpilan_r <= carpilan_s;
            isaret_r   <= isaret_s;
            islem_r    <= islem_s;
        end
    end

    // Signed fix-up of the 64-bit product and half selection; bitti_o releases the stall
    always_comb begin
        if (isaret_r) begin
            carpim_son_s = ~carpim_r + 64'd1;
        end else begin
            carpim_son_s = carpim_r;
        end
        if (islem_r == CARPMA_MUL) begin
            sonuc_o = carpim_son_s[31:0];
        end else begin
            sonuc_o = carpim_son_s[63:32];
        end
        bitti_o = !basla_i || (durum_r == SONUC);
    end

endmodule

// File: tb/tb_carpma_birimi.sv
// Self-checking bench for carpma_birimi: directed cases with literal results
// plus randomized traffic checked every cycle against a 64-bit product model.
module tb_carpma_birimi;

    logic        clk_i;
    logic        rst_ni;
    logic        basla_i;
    logic [1:0]  islem_i;
    logic [31:0] carpilan_i;
    logic [31:0] carpan_i;
    logic [31:0] sonuc_o;
    logic        bitti_o;

    int checks = 0;
    int errors = 0;

    logic        m_aktif;
    int          m_adim;
    logic [31:0] m_sonuc;
    logic        m_bitti;

    carpma_birimi dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .basla_i    (basla_i),
        .islem_i    (islem_i),
        .carpilan_i (carpilan_i),
        .carpan_i   (carpan_i),
        .sonuc_o    (sonuc_o),
        .bitti_o    (bitti_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic kontrol(input string ad, input logic [31:0] gercek, input logic [31:0] beklenen_v);
        checks++;
        if (gercek !== beklenen_v) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", ad, gercek, beklenen_v, $time);
        end
    endtask

    // Reference: selected half of the mathematically exact product
    function automatic logic [31:0] beklenen(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb;
        longint ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ub = longint'({32'h0, b});
        case (op)
            2'b00:   p = {32'h0, a} * {32'h0, b};
            2'b01:   p = sa * sb;
            2'b10:   p = sa * ub;
            default: p = {32'h0, a} * {32'h0, b};
        endcase
        return (op == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    function automatic logic [31:0] rastgele_isle();
        logic [31:0] v;
        case ($urandom_range(0, 5))
            0:       v = 32'h0000_0000;
            1:       v = 32'h8000_0000;
            2:       v = 32'hFFFF_FFFF;
            3:       v = 32'h0000_0001;
            default: v = $urandom();
        endcase
        return v;
    endfunction

    // Compare process: a request completes 33 cycles after the cycle it is accepted
    initial begin
        m_aktif = 1'b0;
        m_adim  = 0;
        m_sonuc = 32'd0;
        m_bitti = 1'b1;
        forever begin
            @(negedge clk_i);
            if (!rst_ni) begin
                m_aktif = 1'b0;
                m_adim  = 0;
                kontrol("reset sonuc", sonuc_o, 32'd0);
            end else begin
                if (!m_aktif) begin
                    if (basla_i) begin
                        m_aktif = 1'b1;
                        m_adim  = 0;
                        m_sonuc = beklenen(islem_i, carpilan_i, carpan_i);
                        m_bitti = 1'b0;
                    end else begin
                        m_bitti = 1'b1;
                    end
                end else if (!basla_i) begin
                    m_bitti = 1'b1;
                    m_aktif = 1'b0;
                end else if (m_adim == 33) begin
                    m_bitti = 1'b1;
                    kontrol("model sonuc", sonuc_o, m_sonuc);
                    m_aktif = 1'b0;
                end else begin
                    m_bitti = 1'b0;
                end
                kontrol("bitti", {31'd0, bitti_o}, {31'd0, m_bitti});
                if (m_aktif) m_adim++;
            end
        end
    end

    task automatic bitti_bekle(output int gecikme);
        gecikme = -1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk_i);
            if (bitti_o) begin
                gecikme = c;
                break;
            end
        end
    endtask

    task automatic islem_yap(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] beklenen_v, input string ad);
        int gecikme;
        @(posedge clk_i); #1;
        islem_i    = op;
        carpilan_i = a;
        carpan_i   = b;
        basla_i    = 1'b1;
        bitti_bekle(gecikme);
        kontrol({ad, " gecikme"}, 32'(gecikme), 32'd33);
        if (gecikme >= 0) kontrol({ad, " sonuc"}, sonuc_o, beklenen_v);
        @(posedge clk_i); #1;
        basla_i = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int gecikme;
        logic iptal;
        int uzunluk;

        rst_ni     = 1'b0;
        basla_i    = 1'b0;
        islem_i    = 2'b00;
        carpilan_i = 32'd0;
        carpan_i   = 32'd0;
        #1;
        kontrol("reset sonuc_o", sonuc_o, 32'd0);
        kontrol("reset bitti_o", {31'd0, bitti_o}, 32'd1);
        repeat (2) @(posedge clk_i);
        #3 rst_ni = 1'b1;

        kontrol("model MULHU -1*-1", beklenen(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFE);
        kontrol("model MULHSU -1*-1", beklenen(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFF);
        kontrol("model MULH min*min", beklenen(2'b01, 32'h8000_0000, 32'h8000_0000), 32'h4000_0000);
        kontrol("model MUL -2*3", beklenen(2'b00, 32'hFFFF_FFFE, 32'd3), 32'hFFFF_FFFA);

        islem_yap(2'b00, 32'd7, 32'd6, 32'h0000_002A, "MUL 7*6");
        #1 kontrol("bosta bitti_o", {31'd0, bitti_o}, 32'd1);

        islem_yap(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "MULHU -1*-1");
        islem_yap(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, "MUL -1*-1");
        islem_yap(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, "MULH -1*-1");
        islem_yap(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "MULHSU -1*-1");
        islem_yap(2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, "MULH min*min");
        islem_yap(2'b01, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, "MULH -2*3");
        islem_yap(2'b00, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFA, "MUL -2*3");
        islem_yap(2'b01, 32'd0, 32'h1234_5678, 32'h0000_0000, "MULH 0*x");

        // Abort in cycle 10, then a fresh request
        @(posedge clk_i); #1;
        islem_i    = 2'b01;
        carpilan_i = 32'h1234_5678;
        carpan_i   = 32'h8765_4321;
        basla_i    = 1'b1;
        repeat (10) @(posedge clk_i);
        #1 basla_i = 1'b0;
        #1 kontrol("iptal bitti_o", {31'd0, bitti_o}, 32'd1);
        islem_yap(2'b11, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, "MULHU sonrasi iptal");

        // Asynchronous reset in the middle of cycle 15
        @(posedge clk_i); #1;
        islem_i    = 2'b00;
        carpilan_i = 32'h1234_5678;
        carpan_i   = 32'h9ABC_DEF1;
        basla_i    = 1'b1;
        repeat (15) @(posedge clk_i);
        #3 rst_ni = 1'b0;
        #1 kontrol("async reset sonuc_o", sonuc_o, 32'd0);
        basla_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #3 rst_ni = 1'b1;
        islem_yap(2'b00, 32'd3, 32'd5, 32'd15, "MUL 3*5 reset sonrasi");

        // Back-to-back with operands changed during the result cycle
        @(posedge clk_i); #1;
        islem_i    = 2'b00;
        carpilan_i = 32'd2;
        carpan_i   = 32'd3;
        basla_i    = 1'b1;
        bitti_bekle(gecikme);
        kontrol("ardisik 1 gecikme", 32'(gecikme), 32'd33);
        kontrol("ardisik 1 sonuc", sonuc_o, 32'd6);
        #1;
        islem_i    = 2'b01;
        carpilan_i = 32'hFFFF_FFFF;
        carpan_i   = 32'd5;
        bitti_bekle(gecikme);
        kontrol("ardisik 2 gecikme", 32'(gecikme), 32'd33);
        kontrol("ardisik 2 sonuc", sonuc_o, 32'hFFFF_FFFF);
        @(posedge clk_i); #1;
        basla_i = 1'b0;

        // Random traffic: aborts, ignored operand changes, back-to-back and idle gaps
        for (int n = 0; n < 1000; n++) begin
            @(posedge clk_i); #1;
            islem_i    = 2'($urandom_range(0, 3));
            carpilan_i = rastgele_isle();
            carpan_i   = rastgele_isle();
            basla_i    = 1'b1;
            iptal      = ($urandom_range(0, 7) == 0);
            uzunluk    = iptal ? int'($urandom_range(1, 33)) : 33;
            for (int c = 1; c <= uzunluk; c++) begin
                @(posedge clk_i); #1;
                if ($urandom_range(0, 3) == 0) begin
                    islem_i    = 2'($urandom_range(0, 3));
                    carpilan_i = $urandom();
                    carpan_i   = $urandom();
                end
            end
            if (iptal) begin
                basla_i = 1'b0;
            end else if ($urandom_range(0, 1) == 0) begin
                @(posedge clk_i); #1;
                basla_i = 1'b0;
            end
            if (!basla_i) repeat ($urandom_range(0, 2)) @(posedge clk_i);
        end

        @(posedge clk_i); #1;
        basla_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
